// File: rtl/network_output_schedule_pq_pkg.sv
// rtl/network_output_schedule_pq_pkg.sv - shared state encodings and default parameters
package network_output_schedule_pq_pkg;

   localparam int DEF_QUEUE_NUM = 8;
   localparam int DEF_BUFID_W   = 9;
   localparam int DEF_TAG_W     = 48;
   localparam int DEF_CNT_W     = 10;
   localparam int DEF_SP_NUM    = 3;

   typedef enum logic [1:0] {
      OSC_IDLE      = 2'd0,
      OSC_RD        = 2'd1,
      OSC_WAIT_DATA = 2'd2,
      OSC_WAIT_ACK  = 2'd3
   } osc_state_e;

endpackage

// File: rtl/network_output_schedule_pq_queue_select_arbiter.sv
// rtl/network_output_schedule_pq_queue_select_arbiter.sv - combinational strict-priority + round-robin queue pick
module queue_select_arbiter
   import network_output_schedule_pq_pkg::*;
#(
   parameter int  QUEUE_NUM = DEF_QUEUE_NUM,
   parameter int  SP_NUM    = DEF_SP_NUM,
   localparam int QW        = $clog2(QUEUE_NUM)
) (
   input  logic [QUEUE_NUM-1:0] iv_eligible,
   input  logic [QW-1:0]        iv_rr_ptr,
   output logic                 o_any,
   output logic [QW-1:0]        ov_sel,
   output logic                 o_sel_rr,
   output logic [QW-1:0]        ov_rr_ptr_next
);

   localparam int RR_NUM = QUEUE_NUM - SP_NUM;

   logic          w_sp_hit;
   logic          w_rr_hit;
   logic [QW:0]   w_rr_sum;
   logic [QW-1:0] w_rr_idx;

   always_comb begin
      w_sp_hit       = 1'b0;
      w_rr_hit       = 1'b0;
      w_rr_sum       = '0;
      w_rr_idx       = '0;
      ov_sel         = '0;
      o_any          = 1'b0;
      o_sel_rr       = 1'b0;
      ov_rr_ptr_next = iv_rr_ptr;
      // ascending scan: the last eligible SP queue seen is the highest index
      for (int i = RR_NUM; i < QUEUE_NUM; i++) begin
         if (iv_eligible[i]) begin
            w_sp_hit = 1'b1;
            ov_sel   = QW'(i);
         end
      end
      if (!w_sp_hit) begin
         for (int k = 0; k < RR_NUM; k++) begin
            w_rr_sum = {1'b0, iv_rr_ptr} + (QW+1)'(k);
            if (w_rr_sum >= (QW+1)'(RR_NUM)) begin
               w_rr_sum = w_rr_sum - (QW+1)'(RR_NUM);
            end
            w_rr_idx = w_rr_sum[QW-1:0];
            if (!w_rr_hit && iv_eligible[w_rr_idx]) begin
               w_rr_hit = 1'b1;
               ov_sel   = w_rr_idx;
            end
         end
      end
      o_any    = w_sp_hit | w_rr_hit;
      o_sel_rr = w_rr_hit;
      if (w_rr_hit) begin
         ov_rr_ptr_next = (int'(ov_sel) + 1 >= RR_NUM) ? '0 : QW'(int'(ov_sel) + 1);
      end
   end

endmodule

// File: rtl/network_output_schedule_pq.sv
// rtl/network_output_schedule_pq.sv - per-port output queue scheduler with linked-list heads and descriptor handshake
module network_output_schedule_pq
   import network_output_schedule_pq_pkg::*;
#(
   parameter int  QUEUE_NUM = DEF_QUEUE_NUM,
   parameter int  BUFID_W   = DEF_BUFID_W,
   parameter int  TAG_W     = DEF_TAG_W,
   parameter int  CNT_W     = DEF_CNT_W,
   parameter int  SP_NUM    = DEF_SP_NUM,
   localparam int QW        = $clog2(QUEUE_NUM)
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic [BUFID_W-1:0]       iv_pkt_bufid,
   input  logic [QW-1:0]            iv_queue_id,
   input  logic                     i_queue_id_wr,
   input  logic [QUEUE_NUM-1:0]     iv_gate_ctrl_vector,
   output logic [BUFID_W-1:0]       ov_queue_raddr,
   output logic                     o_queue_rd,
   input  logic [BUFID_W+TAG_W-1:0] iv_rd_queue_data,
   input  logic                     i_rd_queue_data_wr,
   output logic [BUFID_W-1:0]       ov_pkt_bufid,
   output logic [TAG_W-1:0]         ov_tsntag,
   output logic                     o_pkt_bufid_wr,
   input  logic                     i_pkt_bufid_ack,
   output logic [QW-1:0]            ov_schdule_id,
   output logic                     o_schdule_id_wr,
   output logic [QUEUE_NUM-1:0]     ov_queue_empty,
   output logic                     o_enq_overflow,
   output logic [1:0]               ov_osc_state
);

   osc_state_e           r_state;
   osc_state_e           w_state_nxt;
   logic [QW-1:0]        r_sel_q;
   logic [QW-1:0]        r_rr_ptr;
   logic [BUFID_W-1:0]   r_head  [QUEUE_NUM];
   logic [CNT_W-1:0]     r_count [QUEUE_NUM];
   logic                 r_queue_rd;
   logic [BUFID_W-1:0]   r_raddr;
   logic                 r_sched_wr;
   logic [QW-1:0]        r_sched_id;
   logic                 r_pkt_wr;
   logic [BUFID_W-1:0]   r_pkt_bufid;
   logic [TAG_W-1:0]     r_tsntag;
   logic                 r_ovf;

   logic [QUEUE_NUM-1:0] w_eligible;
   logic [QUEUE_NUM-1:0] w_enq_vec;
   logic [QUEUE_NUM-1:0] w_deq_vec;
   logic [QUEUE_NUM-1:0] w_full_vec;
   logic [QUEUE_NUM-1:0] w_empty_vec;
   logic                 w_any;
   logic [QW-1:0]        w_sel;
   logic                 w_sel_rr;
   logic [QW-1:0]        w_rr_ptr_next;
   logic                 w_deq;
   logic                 w_drop;
   logic [BUFID_W-1:0]   w_next_bufid;

   assign w_deq        = (r_state == OSC_WAIT_DATA) & i_rd_queue_data_wr;
   assign w_next_bufid = iv_rd_queue_data[BUFID_W+TAG_W-1:TAG_W];

   always_comb begin
      w_eligible  = '0;
      w_enq_vec   = '0;
      w_deq_vec   = '0;
      w_full_vec  = '0;
      w_empty_vec = '0;
      for (int q = 0; q < QUEUE_NUM; q++) begin
         w_empty_vec[q] = (r_count[q] == '0);
         w_full_vec[q]  = (r_count[q] == '1);
         w_eligible[q]  = iv_gate_ctrl_vector[q] & ~w_empty_vec[q];
         w_enq_vec[q]   = i_queue_id_wr & (iv_queue_id == QW'(q));
         w_deq_vec[q]   = w_deq & (r_sel_q == QW'(q));
      end
   end

   // a simultaneous dequeue frees a slot, so a full queue only drops when not draining
   assign w_drop = |(w_enq_vec & w_full_vec & ~w_deq_vec);

   queue_select_arbiter #(
      .QUEUE_NUM (QUEUE_NUM),
      .SP_NUM    (SP_NUM)
   ) u_arbiter (
      .iv_eligible    (w_eligible),
      .iv_rr_ptr      (r_rr_ptr),
      .o_any          (w_any),
      .ov_sel         (w_sel),
      .o_sel_rr       (w_sel_rr),
      .ov_rr_ptr_next (w_rr_ptr_next)
   );

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state <= OSC_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         OSC_IDLE:      if (w_any)              w_state_nxt = OSC_RD;
         OSC_RD:                                w_state_nxt = OSC_WAIT_DATA;
         OSC_WAIT_DATA: if (i_rd_queue_data_wr) w_state_nxt = OSC_WAIT_ACK;
         OSC_WAIT_ACK:  if (i_pkt_bufid_ack)    w_state_nxt = OSC_IDLE;
         default:                               w_state_nxt = OSC_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_sel_q     <= '0;
         r_rr_ptr    <= '0;
         r_queue_rd  <= 1'b0;
         r_raddr     <= '0;
         r_sched_wr  <= 1'b0;
         r_sched_id  <= '0;
         r_pkt_wr    <= 1'b0;
         r_pkt_bufid <= '0;
         r_tsntag    <= '0;
         r_ovf       <= 1'b0;
         for (int q = 0; q < QUEUE_NUM; q++) begin
            r_head[q]  <= '0;
            r_count[q] <= '0;
         end
      end else begin
         r_queue_rd <= 1'b0;
         r_sched_wr <= 1'b0;
         r_pkt_wr   <= 1'b0;
         r_ovf      <= w_drop;
         if (r_state == OSC_IDLE && w_any) begin
            r_sel_q    <= w_sel;
            r_queue_rd <= 1'b1;
            r_raddr    <= r_head[w_sel];
            r_sched_wr <= 1'b1;
            r_sched_id <= w_sel;
            if (w_sel_rr) begin
               r_rr_ptr <= w_rr_ptr_next;
            end
         end
         if (w_deq) begin
            r_pkt_wr    <= 1'b1;
            r_pkt_bufid <= r_head[r_sel_q];
            r_tsntag    <= iv_rd_queue_data[TAG_W-1:0];
         end
         for (int q = 0; q < QUEUE_NUM; q++) begin
            if (w_enq_vec[q] && w_deq_vec[q]) begin
               // last element leaving while a new one arrives: memory link is stale
               r_head[q] <= (r_count[q] == CNT_W'(1)) ? iv_pkt_bufid : w_next_bufid;
            end else if (w_enq_vec[q]) begin
               if (w_empty_vec[q]) begin
                  r_head[q]  <= iv_pkt_bufid;
                  r_count[q] <= CNT_W'(1);
               end else if (!w_full_vec[q]) begin
                  r_count[q] <= r_count[q] + CNT_W'(1);
               end
            end else if (w_deq_vec[q]) begin
               r_head[q]  <= w_next_bufid;
               r_count[q] <= r_count[q] - CNT_W'(1);
            end
         end
      end
   end

   assign ov_queue_raddr  = r_raddr;
   assign o_queue_rd      = r_queue_rd;
   assign ov_pkt_bufid    = r_pkt_bufid;
   assign ov_tsntag       = r_tsntag;
   assign o_pkt_bufid_wr  = r_pkt_wr;
   assign ov_schdule_id   = r_sched_id;
   assign o_schdule_id_wr = r_sched_wr;
   assign ov_queue_empty  = w_empty_vec;
   assign o_enq_overflow  = r_ovf;
   assign ov_osc_state    = r_state;

endmodule

// File: tb/tb_network_output_schedule_pq.sv
// tb/tb_network_output_schedule_pq.sv - scoreboard bench for network_output_schedule_pq
module tb_network_output_schedule_pq;

   localparam int QN  = 8;
   localparam int BW  = 9;
   localparam int TW  = 48;
   localparam int CW  = 10;
   localparam int SPN = 3;
   localparam int QW  = 3;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [BW-1:0]     iv_pkt_bufid;
   logic [QW-1:0]     iv_queue_id;
   logic              i_queue_id_wr;
   logic [QN-1:0]     gate;
   logic [BW-1:0]     ov_queue_raddr;
   logic              o_queue_rd;
   logic [BW+TW-1:0]  iv_rd_queue_data;
   logic              i_rd_queue_data_wr;
   logic [BW-1:0]     ov_pkt_bufid;
   logic [TW-1:0]     ov_tsntag;
   logic              o_pkt_bufid_wr;
   logic              i_pkt_bufid_ack;
   logic [QW-1:0]     ov_schdule_id;
   logic              o_schdule_id_wr;
   logic [QN-1:0]     ov_queue_empty;
   logic              o_enq_overflow;
   logic [1:0]        ov_osc_state;

   int total = 0;
   int bad   = 0;
   int ovf_seen = 0;
   logic [QW+BW-1:0] exp_rd[$];
   logic [BW+TW-1:0] exp_desc[$];

   always #4 clk = ~clk;

   network_output_schedule_pq #(
      .QUEUE_NUM (QN), .BUFID_W (BW), .TAG_W (TW), .CNT_W (CW), .SP_NUM (SPN)
   ) dut (
      .i_clk               (clk),
      .i_rst_n             (rst_n),
      .iv_pkt_bufid        (iv_pkt_bufid),
      .iv_queue_id         (iv_queue_id),
      .i_queue_id_wr       (i_queue_id_wr),
      .iv_gate_ctrl_vector (gate),
      .ov_queue_raddr      (ov_queue_raddr),
      .o_queue_rd          (o_queue_rd),
      .iv_rd_queue_data    (iv_rd_queue_data),
      .i_rd_queue_data_wr  (i_rd_queue_data_wr),
      .ov_pkt_bufid        (ov_pkt_bufid),
      .ov_tsntag           (ov_tsntag),
      .o_pkt_bufid_wr      (o_pkt_bufid_wr),
      .i_pkt_bufid_ack     (i_pkt_bufid_ack),
      .ov_schdule_id       (ov_schdule_id),
      .o_schdule_id_wr     (o_schdule_id_wr),
      .ov_queue_empty      (ov_queue_empty),
      .o_enq_overflow      (o_enq_overflow),
      .ov_osc_state        (ov_osc_state)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      total++;
      bad++;
      $display("FAIL %s: got event expected none", name);
   endtask

   // monitor: pops expectations whenever the DUT strobes an output
   initial begin
      forever begin
         @(negedge clk);
         if (o_queue_rd) begin
            if (exp_rd.size() == 0) fail("rd_unexpected");
            else chk("rd_strobe", {o_schdule_id_wr, ov_schdule_id, ov_queue_raddr}, {1'b1, exp_rd.pop_front()});
         end else if (o_schdule_id_wr) begin
            fail("sched_without_rd");
         end
         if (o_pkt_bufid_wr) begin
            if (exp_desc.size() == 0) fail("desc_unexpected");
            else chk("desc", {ov_pkt_bufid, ov_tsntag}, exp_desc.pop_front());
         end
         if (o_enq_overflow) ovf_seen++;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected test end");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic enq(input int q, input int b);
      iv_queue_id   = QW'(q);
      iv_pkt_bufid  = BW'(b);
      i_queue_id_wr = 1'b1;
      tick();
      i_queue_id_wr = 1'b0;
   endtask

   task automatic serve(input int q, input int head, input int nxt, input logic [TW-1:0] tag,
                        input int ack_delay, input bit side_enq, input int sq, input int sb);
      int n;
      exp_rd.push_back({QW'(q), BW'(head)});
      exp_desc.push_back({BW'(head), tag});
      n = 0;
      while (!o_queue_rd && n < 40) begin
         tick();
         n++;
      end
      if (!o_queue_rd) begin
         fail("timeout_rd");
         return;
      end
      tick();
      iv_rd_queue_data   = {BW'(nxt), tag};
      i_rd_queue_data_wr = 1'b1;
      if (side_enq) begin
         iv_queue_id   = QW'(sq);
         iv_pkt_bufid  = BW'(sb);
         i_queue_id_wr = 1'b1;
      end
      tick();
      i_rd_queue_data_wr = 1'b0;
      i_queue_id_wr      = 1'b0;
      if (!o_pkt_bufid_wr) begin
         fail("timeout_desc");
         return;
      end
      repeat (ack_delay) tick();
      if (ack_delay > 0) chk("desc_hold", {ov_pkt_bufid, ov_tsntag}, {BW'(head), tag});
      i_pkt_bufid_ack = 1'b1;
      tick();
      i_pkt_bufid_ack = 1'b0;
   endtask

   initial begin
      int n;
      rst_n              = 1'b0;
      iv_pkt_bufid       = '0;
      iv_queue_id        = '0;
      i_queue_id_wr      = 1'b0;
      gate               = '0;
      iv_rd_queue_data   = '0;
      i_rd_queue_data_wr = 1'b0;
      i_pkt_bufid_ack    = 1'b0;
      repeat (3) tick();
      chk("rst_empty", ov_queue_empty, 8'hFF);
      chk("rst_state", ov_osc_state, 2'd0);
      chk("rst_strobes", {o_queue_rd, o_pkt_bufid_wr, o_schdule_id_wr, o_enq_overflow}, 4'h0);
      chk("rst_data", {ov_pkt_bufid, ov_tsntag, ov_queue_raddr}, 0);
      rst_n = 1'b1;
      tick();

      // single packet to q7
      enq(7, 5);
      chk("q7_nonempty", ov_queue_empty, 8'h7F);
      gate = 8'hFF;
      serve(7, 5, 0, 48'hABCD_EF01_2345, 2, 1'b0, 0, 0);
      chk("q7_drained", ov_queue_empty, 8'hFF);

      // strict priority and gate masking
      gate = 8'h00;
      enq(6, 10);
      enq(7, 11);
      gate = 8'hFF;
      serve(7, 11, 0, 48'h0000_0000_0711, 0, 1'b0, 0, 0);
      serve(6, 10, 0, 48'h0000_0000_0610, 0, 1'b0, 0, 0);
      gate = 8'h00;
      enq(6, 12);
      enq(7, 13);
      gate = 8'h7F;
      serve(6, 12, 0, 48'h0000_0000_0612, 0, 1'b0, 0, 0);
      gate = 8'hFF;
      serve(7, 13, 0, 48'h0000_0000_0713, 0, 1'b0, 0, 0);

      // round robin across q0/q2/q4
      gate = 8'h00;
      enq(0, 30); enq(0, 31);
      enq(2, 40); enq(2, 41);
      enq(4, 50); enq(4, 51);
      gate = 8'h1F;
      serve(0, 30, 31, 48'h0410_0000_0001, 0, 1'b0, 0, 0);
      serve(2, 40, 41, 48'h0410_0000_0002, 0, 1'b0, 0, 0);
      serve(4, 50, 51, 48'h0410_0000_0003, 0, 1'b0, 0, 0);
      serve(0, 31, 0,  48'h0410_0000_0004, 0, 1'b0, 0, 0);
      serve(2, 41, 0,  48'h0410_0000_0005, 0, 1'b0, 0, 0);
      serve(4, 51, 0,  48'h0410_0000_0006, 0, 1'b0, 0, 0);
      chk("rr_drained", ov_queue_empty, 8'hFF);

      // enqueue coinciding with dequeue of last element; other-queue enqueue alongside
      gate = 8'h00;
      enq(3, 60);
      gate = 8'h08;
      serve(3, 60, 99, 48'h0420_0000_0060, 0, 1'b1, 3, 20);
      chk("q3_kept", ov_queue_empty, 8'hF7);
      serve(3, 20, 0, 48'h0420_0000_0020, 0, 1'b1, 5, 70);
      chk("q5_side_enq", ov_queue_empty, 8'hDF);
      gate = 8'h20;
      serve(5, 70, 0, 48'h0420_0000_0070, 0, 1'b0, 0, 0);
      chk("q5_drained", ov_queue_empty, 8'hFF);

      // fill q1 to 1023, overflow, then drain exactly 1023
      gate = 8'h00;
      for (int k = 0; k < 1023; k++) enq(1, (100 + k) % 512);
      chk("ovf_none_yet", ovf_seen, 0);
      enq(1, 487);
      tick();
      chk("ovf_count", ovf_seen, 1);
      gate = 8'h02;
      for (int k = 0; k < 1023; k++) begin
         serve(1, (100 + k) % 512, (101 + k) % 512, TW'(48'h0430_0000_0000 + k), 0, 1'b0, 0, 0);
         if (k == 1021) chk("q1_last_left", ov_queue_empty, 8'hFD);
      end
      chk("q1_drained", ov_queue_empty, 8'hFF);

      // reset while waiting for ack
      gate = 8'h00;
      enq(2, 77);
      gate = 8'h04;
      exp_rd.push_back({QW'(2), BW'(77)});
      exp_desc.push_back({BW'(77), 48'hDEAD_BEEF_0077});
      n = 0;
      while (!o_queue_rd && n < 40) begin
         tick();
         n++;
      end
      tick();
      iv_rd_queue_data   = {BW'(0), 48'hDEAD_BEEF_0077};
      i_rd_queue_data_wr = 1'b1;
      tick();
      i_rd_queue_data_wr = 1'b0;
      chk("in_wait_ack", ov_osc_state, 2'd3);
      rst_n = 1'b0;
      tick();
      chk("mid_rst_state", ov_osc_state, 2'd0);
      chk("mid_rst_data", {ov_pkt_bufid, ov_tsntag}, 0);
      chk("mid_rst_strobes", {o_queue_rd, o_pkt_bufid_wr, o_schdule_id_wr, o_enq_overflow}, 4'h0);
      chk("mid_rst_empty", ov_queue_empty, 8'hFF);
      rst_n = 1'b1;
      i_pkt_bufid_ack = 1'b1;
      tick();
      i_pkt_bufid_ack = 1'b0;
      repeat (3) tick();
      chk("late_ack_ignored", ov_osc_state, 2'd0);
      chk("late_ack_data", {ov_pkt_bufid, ov_tsntag}, 0);

      chk("exp_rd_left", exp_rd.size(), 0);
      chk("exp_desc_left", exp_desc.size(), 0);
      chk("ovf_total", ovf_seen, 1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/network_output_schedule_pq.md
NETWORK_OUTPUT_SCHEDULE_PQ -- requirements
Module: network_output_schedule_pq

Interface
REQ-001 Parameter QUEUE_NUM, default 8, number of queues per port (power of 2, 2..16).
REQ-002 Parameter BUFID_W, default 9, packet buffer id width.
REQ-003 Parameter TAG_W, default 48, TSN tag width.
REQ-004 Parameter CNT_W, default 10, per-queue occupancy counter width.
REQ-005 Parameter SP_NUM, default 3, number of highest-index queues served strict priority; rest served round-robin.
REQ-006 Clocking and reset SHALL be exactly: one clock; reset is synchronous and active-low.
REQ-007 i_clk  in  1  single clock, 125 MHz.
REQ-008 i_rst_n  in  1  synchronous active-low reset.
REQ-009 iv_pkt_bufid  in  BUFID_W  enqueued packet buffer id.
REQ-010 iv_queue_id  in  log2(QUEUE_NUM)  target queue of enqueue.
REQ-011 i_queue_id_wr  in  1  enqueue strobe, one cycle.
REQ-012 iv_gate_ctrl_vector  in  QUEUE_NUM  gate open bitmap, bit q = queue q.
REQ-013 ov_queue_raddr / o_queue_rd  out  BUFID_W / 1  link-memory read address / one-cycle read strobe.
REQ-014 iv_rd_queue_data / i_rd_queue_data_wr  in  BUFID_W+TAG_W / 1  {next_bufid, tsntag} / valid strobe.
REQ-015 ov_pkt_bufid / ov_tsntag / o_pkt_bufid_wr  out  BUFID_W / TAG_W / 1  descriptor to network_tx, one-cycle strobe.
REQ-016 i_pkt_bufid_ack  in  1  network_tx accepted descriptor.
REQ-017 ov_schdule_id / o_schdule_id_wr  out  log2(QUEUE_NUM) / 1  selected queue, one-cycle strobe.
REQ-018 ov_queue_empty  out  QUEUE_NUM  bit q = (count[q]==0).
REQ-019 o_enq_overflow  out  1  one-cycle pulse when enqueue dropped.
REQ-020 ov_osc_state  out  2  FSM state encoding.

Function
REQ-021 Per queue: head[q] (BUFID_W) and count[q] (CNT_W) registers.
REQ-022 Eligible[q] = gate[q] & (count[q]!=0), sampled in IDLE only.
REQ-023 Selection: highest eligible index among SP queues (index >= QUEUE_NUM-SP_NUM) wins; else round-robin among eligible RR queues starting at rr_ptr.
REQ-024 rr_ptr updated to selected RR queue + 1 (wrapping within RR range) only when an RR queue is selected.
REQ-025 FSM IDLE(0) -> RD(1) -> WAIT_DATA(2) -> WAIT_ACK(3) -> IDLE.
REQ-026 IDLE with any eligible: latch sel_q; next cycle o_queue_rd=1, ov_queue_raddr=head[sel_q], o_schdule_id_wr=1, ov_schdule_id=sel_q; enter WAIT_DATA.
REQ-027 WAIT_DATA on i_rd_queue_data_wr: next cycle o_pkt_bufid_wr=1, ov_pkt_bufid=head[sel_q], ov_tsntag=data[TAG_W-1:0]; head[sel_q]<=next_bufid; count[sel_q] decrements; enter WAIT_ACK.
REQ-028 WAIT_ACK holds ov_pkt_bufid/ov_tsntag stable until i_pkt_bufid_ack; ack returns to IDLE next cycle; earliest reselection one cycle later.
REQ-029 Ack arriving in any state other than WAIT_ACK SHALL be ignored.
REQ-030 Gate closing after selection SHALL NOT abort the in-flight descriptor.
REQ-031 Enqueue with count[q]==0: head[q]<=iv_pkt_bufid, count=1.
REQ-032 Enqueue with count[q]==all-ones: dropped, count/head unchanged, o_enq_overflow pulses.
REQ-033 Enqueue and dequeue completion on same queue same cycle: net count unchanged; if count was 1, head<=iv_pkt_bufid (memory next_bufid ignored).
REQ-034 Enqueue to other queue during dequeue SHALL be processed independently in the same cycle.

Reset
REQ-035 On reset: all counts 0, heads 0, rr_ptr 0, FSM IDLE, all strobes 0, data outputs 0, ov_queue_empty all-ones.
REQ-036 Reset mid-operation discards in-flight descriptor; no ack expected afterward.

Structure
REQ-037 Shared package holds state encodings and default parameter constants.
REQ-038 One sub-module queue_select_arbiter (combinational SP + RR pick, parametrised by QUEUE_NUM/SP_NUM).

Verification
REQ-039 Enqueue bufid 5 to q7, gate 0xFF -> rd strobe raddr=5, then descriptor bufid=5 with returned tag, count[7]=0.
REQ-040 q7 and q6 non-empty, gate 0xFF -> q7 served before q6; gate 0x7F -> q6 served first.
REQ-041 q0,q2,q4 each 2 packets, gate 0x1F, SP_NUM=3 -> service order 0,2,4,0,2,4.
REQ-042 count[3]==1 in WAIT_DATA, enqueue bufid 20 to q3 coinciding with data valid -> head[3]=20, count[3]=1.
REQ-043 Fill q1 to 1023 then enqueue -> o_enq_overflow pulse, count stays 1023.
REQ-044 Assert reset in WAIT_ACK -> all outputs reset values next cycle, late ack ignored.
